// File: rtl/bitstream_pkg.sv
// Shared types and sizing helpers for the stochastic bitstream decoder.
package bitstream_pkg;

  localparam int DEFAULT_STREAM_LENGTH = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } dec_state_t;

  // Count width that holds 0..length inclusive.
  function automatic int stream_width(input int length);
    return $clog2(length) + 1;
  endfunction

endpackage

// File: rtl/bitstream_decoder_window_counter.sv
// Valid-sample counter for one decode window; flags when the next accepted
// sample is the last one of the window.
module window_counter
  import bitstream_pkg::*;
#(
  parameter int LENGTH = DEFAULT_STREAM_LENGTH,
  parameter int WIDTH  = stream_width(LENGTH)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(LENGTH - 1);

  logic [WIDTH-1:0] sample_cnt_q;
  logic [WIDTH-1:0] sample_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    if (clear) begin
      sample_cnt_d = '0;
    end else if (enable) begin
      sample_cnt_d = sample_cnt_q + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs before any of them update at the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign last = (sample_cnt_q == LAST_IDX);

endmodule

// File: rtl/bitstream_decoder.sv
// Decodes a stochastic bitstream by counting ones over LENGTH valid samples.
// Build option: define BITSTREAM_DECODER_BIPOLAR_EN for a bipolar (2*ones-LENGTH) result.
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int LENGTH = DEFAULT_STREAM_LENGTH,
  parameter int WIDTH  = stream_width(LENGTH)
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           start,
  input  logic           bit_in,
  input  logic           bit_valid,
  output logic [WIDTH:0] value,
  output logic           done,
  output logic           busy
);

`ifdef BITSTREAM_DECODER_BIPOLAR_EN
  localparam logic [WIDTH:0] LEN_V = (WIDTH+1)'(LENGTH);
`endif

  dec_state_t       state_q, state_d;
  logic [WIDTH-1:0] ones_q, ones_d;
  logic [WIDTH:0]   value_q, value_d;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_last;

  window_counter #(
    .LENGTH(LENGTH),
    .WIDTH (WIDTH)
  ) u_window_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cnt_clear),
    .enable(cnt_en),
    .last  (cnt_last)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    value_d   = value_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          ones_d    = '0;
          cnt_clear = 1'b1;
        end
      end
      ACCUM: begin
        if (bit_valid) begin
          cnt_en = 1'b1;
          ones_d = ones_q + WIDTH'(bit_in);
          if (cnt_last) begin
            state_d = DONE;
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
            value_d = {ones_d, 1'b0} - LEN_V;
`else
            value_d = {1'b0, ones_d};
`endif
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d   = ACCUM;
          ones_d    = '0;
          cnt_clear = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ones_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      value_q <= value_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign value = value_q;
  assign done  = (state_q == DONE);
  assign busy  = (state_q == ACCUM);

endmodule

// File: tb/tb_bitstream_decoder.sv
// Randomized self-checking bench for bitstream_decoder against a ones-count model.
module tb_bitstream_decoder;
  import bitstream_pkg::*;

  localparam int LENGTH = DEFAULT_STREAM_LENGTH;
  localparam int WIDTH  = stream_width(LENGTH);

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           start = 1'b0;
  logic           bit_in = 1'b0;
  logic           bit_valid = 1'b0;
  logic [WIDTH:0] value;
  logic           done;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int windows = 0;
  int done_at[$];

  bitstream_decoder #(.LENGTH(LENGTH)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .value    (value),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Record the cycle of every observed done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) done_at.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [WIDTH:0] exp_value(input int ones);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
    return (WIDTH+1)'(2 * ones - LENGTH);
`else
    return (WIDTH+1)'(ones);
`endif
  endfunction

  // Bit pattern by index of accepted sample.
  function automatic logic gen_bit(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (idx % 2 == 0);
      3:       return (idx < 384);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic gen_valid(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3 != 2);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic run_window(input string name, input int bmode, input int vmode,
                            input bit hold, input bit rand_start);
    int accepted = 0;
    int ones = 0;
    int c = 0;
    logic v, b;
    start     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'b1;
    tick();
    check({name, "_start_bd"}, {busy, done}, 2'b10);
    while (accepted < LENGTH) begin
      v = gen_valid(vmode, c);
      b = v ? gen_bit(bmode, accepted) : 1'b1;
      bit_valid = v;
      bit_in    = b;
      start     = hold ? 1'b1 : (rand_start ? 1'($urandom_range(0, 1)) : 1'b0);
      tick();
      c++;
      if (v) begin
        accepted++;
        ones += int'(b);
      end
      if (accepted < LENGTH) check({name, "_accum_bd"}, {busy, done}, 2'b10);
    end
    windows++;
    check({name, "_done_bd"}, {busy, done}, 2'b01);
    check({name, "_value"}, value, exp_value(ones));
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
    start     = hold;
    if (!hold) begin
      tick();
      check({name, "_idle_bd"}, {busy, done}, 2'b00);
      check({name, "_held"}, value, exp_value(ones));
    end
  endtask

  initial begin
    int n0;
    repeat (2) tick();
    check("rst_value", value, 0);
    check("rst_bd", {busy, done}, 2'b00);
    n_rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      tick();
    end
    check("idle_ignore_bd", {busy, done}, 2'b00);
    check("idle_ignore_value", value, 0);

    run_window("ones", 0, 0, 1'b0, 1'b0);
    run_window("zeros", 1, 0, 1'b0, 1'b1);
    run_window("alt", 2, 0, 1'b0, 1'b1);
    run_window("skew", 3, 1, 1'b0, 1'b1);

    // Abort a window after 200 valid ones.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_value", value, 0);
    check("mid_rst_bd", {busy, done}, 2'b00);
    tick();
    n_rst = 1'b1;
    tick();
    check("post_rst_bd", {busy, done}, 2'b00);
    check("post_rst_value", value, 0);
    run_window("after_rst", 0, 0, 1'b0, 1'b0);

    n0 = done_at.size();
    run_window("b2b_a", 0, 0, 1'b1, 1'b0);
    run_window("b2b_b", 1, 0, 1'b0, 1'b0);
    if (done_at.size() >= n0 + 2)
      check("b2b_spacing", done_at[n0+1] - done_at[n0], LENGTH + 1);
    else
      check("b2b_pulses", done_at.size() - n0, 2);

    for (int i = 0; i < 3; i++) run_window("rand", 4, 2, 1'b0, 1'b1);

    check("done_pulse_count", done_at.size(), windows);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
